// File: rtl/video_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// video_ctrl_pkg
// Shared definitions for the video-chain control blocks.
//   ctrl_state_e   : frame mode controller FSM encoding
//   MODE_W         : width of the board switch / mode-select bus
//   MODE_SOBEL_BIT : mode bit that routes pixels through the Sobel path
//   FRAME_CNT_W    : width of the frame statistics counter
//   LINE_CNT_W     : width of the per-frame line statistics counter
//   cnt_width()    : register width needed to hold 0..max_val (never below 1)
// -----------------------------------------------------------------------------
package video_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_BLANK   = 2'd1,
        ST_PENDING = 2'd2
    } ctrl_state_e;

    localparam int MODE_W         = 4;
    localparam int MODE_SOBEL_BIT = 0;
    localparam int FRAME_CNT_W    = 16;
    localparam int LINE_CNT_W     = 12;

    // Width of a counter that must reach max_val; a zero-width vector is not
    // legal, so one bit is the floor.
    function automatic int cnt_width(input int max_val);
        int w;
        w = $clog2(max_val + 1);
        if (w < 1) begin
            w = 1;
        end else begin
            w = w;
        end
        return w;
    endfunction

endpackage

// File: rtl/sw_debounce.sv
// -----------------------------------------------------------------------------
// sw_debounce
// Two-flop synchroniser followed by a candidate/counter debouncer. The stable
// output only takes a new value once the synchronised input has been equal to
// the candidate for DEB_CYCLES consecutive samples; shorter glitches are lost.
//
// Parameters
//   WIDTH      : number of switch bits
//   DEB_CYCLES : stable samples required before accepting a value (>= 1)
// Ports
//   clk       in   system clock, rising edge
//   rst       in   synchronous active-high reset
//   sw_raw    in   asynchronous switch inputs
//   sw_stable out  debounced switch value (registered)
// -----------------------------------------------------------------------------
module sw_debounce
    import video_ctrl_pkg::*;
#(
    parameter int WIDTH      = 4,
    parameter int DEB_CYCLES = 1_000_000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] sw_raw,
    output logic [WIDTH-1:0] sw_stable
);

    localparam int               CNT_W    = cnt_width(DEB_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

    logic [WIDTH-1:0] sync_meta_r;
    logic [WIDTH-1:0] sw_sync_r;
    logic [WIDTH-1:0] cand_r;
    logic [CNT_W-1:0] cnt_r;
    logic [WIDTH-1:0] stable_r;

    // Two-flop synchroniser bringing the board switches into the clock domain.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_meta_r <= {WIDTH{1'b0}};
            sw_sync_r   <= {WIDTH{1'b0}};
        end else begin
            sync_meta_r <= sw_raw;
            sw_sync_r   <= sync_meta_r;
        end
    end

    // Candidate tracking: any change restarts the count, a full run of equal
    // samples commits the candidate and parks the counter at its last value.
    always_ff @(posedge clk) begin
        if (rst) begin
            cand_r   <= {WIDTH{1'b0}};
            cnt_r    <= {CNT_W{1'b0}};
            stable_r <= {WIDTH{1'b0}};
        end else if (sw_sync_r != cand_r) begin
            cand_r <= sw_sync_r;
            cnt_r  <= {CNT_W{1'b0}};
        end else if (cnt_r == CNT_LAST) begin
            stable_r <= cand_r;
        end else begin
            cnt_r <= cnt_r + CNT_W'(1);
        end
    end

    assign sw_stable = stable_r;

endmodule

// File: rtl/frame_mode_ctrl.sv
// -----------------------------------------------------------------------------
// frame_mode_ctrl
// Frame-synchronous mode controller for the RGB->YCbCr / Sobel / YCbCr->RGB
// chain. Debounced switch requests are held until the next frame start, then
// applied to mode_sel, after which the output is forced black for
// BLANK_FRAMES frames to hide line-buffer warm-up after the datapath switch.
// The same blanking runs once after reset.
//
// Optional feature: define FRAME_MODE_CTRL_STATS_EN to build the frame and
// line statistics counters; otherwise frame_cnt / lines_per_frame read 0.
//
// Parameters
//   DEB_CYCLES   : switch debounce length in clocks (>= 1)
//   BLANK_FRAMES : frames blanked after reset / mode change (0 = no blanking)
// Ports
//   clk             in   system / pixel clock, rising edge
//   rst             in   synchronous active-high reset
//   vs_in           in   vertical sync, rising edge marks frame start
//   hs_in           in   horizontal sync (statistics only, not used for counting)
//   de_in           in   data enable, rising edge counts one active line
//   sw_opt          in   raw board switches
//   mode_sel        out  applied mode; bit MODE_SOBEL_BIT selects Sobel
//   blank_out       out  force output pixels to black
//   switch_pending  out  debounced request waiting for a frame boundary
//   frame_cnt       out  frames since reset (wraps)
//   lines_per_frame out  active lines in the last complete frame (saturates)
// -----------------------------------------------------------------------------
module frame_mode_ctrl
    import video_ctrl_pkg::*;
#(
    parameter int DEB_CYCLES   = 1_000_000,
    parameter int BLANK_FRAMES = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   vs_in,
    input  logic                   hs_in,
    input  logic                   de_in,
    input  logic [MODE_W-1:0]      sw_opt,
    output logic [MODE_W-1:0]      mode_sel,
    output logic                   blank_out,
    output logic                   switch_pending,
    output logic [FRAME_CNT_W-1:0] frame_cnt,
    output logic [LINE_CNT_W-1:0]  lines_per_frame
);

    localparam int              BC_W       = cnt_width(BLANK_FRAMES);
    localparam logic [BC_W-1:0] BLANK_LOAD = BC_W'(BLANK_FRAMES);
    localparam logic [BC_W-1:0] BC_ONE     = BC_W'(1);
    localparam bit              BLANK_EN   = (BLANK_FRAMES > 0);

    logic [MODE_W-1:0] sw_stable_s;
    logic              vs_d_r;
    logic              frame_start_s;

    ctrl_state_e       state_r;
    ctrl_state_e       state_nxt_s;
    logic [BC_W-1:0]   blank_cnt_r;
    logic [BC_W-1:0]   blank_cnt_nxt_s;
    logic [MODE_W-1:0] mode_sel_r;
    logic [MODE_W-1:0] mode_nxt_s;
    logic              blank_out_r;
    logic              switch_pending_r;

    sw_debounce #(
        .WIDTH      (MODE_W),
        .DEB_CYCLES (DEB_CYCLES)
    ) u_sw_debounce (
        .clk       (clk),
        .rst       (rst),
        .sw_raw    (sw_opt),
        .sw_stable (sw_stable_s)
    );

    // Delayed vsync for edge detection. Resetting it high means a vsync that
    // is already high when reset releases does not count as a frame start.
    always_ff @(posedge clk) begin
        if (rst) begin
            vs_d_r <= 1'b1;
        end else begin
            vs_d_r <= vs_in;
        end
    end

    assign frame_start_s = vs_in & ~vs_d_r;

    // FSM state, blank counter and applied mode.
    always_ff @(posedge clk) begin
        if (rst) begin
            if (BLANK_EN) begin
                state_r <= ST_BLANK;
            end else begin
                state_r <= ST_RUN;
            end
            blank_cnt_r <= BLANK_LOAD;
            mode_sel_r  <= {MODE_W{1'b0}};
        end else begin
            state_r     <= state_nxt_s;
            blank_cnt_r <= blank_cnt_nxt_s;
            mode_sel_r  <= mode_nxt_s;
        end
    end

    // Next-state logic. In PENDING the withdrawal test comes first so that a
    // request dropped in the same cycle as a frame start leaves mode_sel alone.
    always_comb begin
        state_nxt_s     = state_r;
        blank_cnt_nxt_s = blank_cnt_r;
        mode_nxt_s      = mode_sel_r;
        case (state_r)
            ST_RUN: begin
                if (sw_stable_s != mode_sel_r) begin
                    state_nxt_s = ST_PENDING;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_PENDING: begin
                if (sw_stable_s == mode_sel_r) begin
                    state_nxt_s = ST_RUN;
                end else if (frame_start_s) begin
                    mode_nxt_s = sw_stable_s;
                    if (BLANK_EN) begin
                        state_nxt_s     = ST_BLANK;
                        blank_cnt_nxt_s = BLANK_LOAD;
                    end else begin
                        state_nxt_s = ST_RUN;
                    end
                end else begin
                    state_nxt_s = ST_PENDING;
                end
            end
            ST_BLANK: begin
                // Switch changes are deliberately ignored here; RUN picks
                // them up on the cycle after BLANK exits.
                if (frame_start_s) begin
                    if (blank_cnt_r <= BC_ONE) begin
                        state_nxt_s     = ST_RUN;
                        blank_cnt_nxt_s = {BC_W{1'b0}};
                    end else begin
                        state_nxt_s     = ST_BLANK;
                        blank_cnt_nxt_s = blank_cnt_r - BC_ONE;
                    end
                end else begin
                    state_nxt_s = ST_BLANK;
                end
            end
            default: begin
                state_nxt_s     = ST_RUN;
                blank_cnt_nxt_s = {BC_W{1'b0}};
            end
        endcase
    end

    // Registered status outputs. blank_out follows the next state so it rises
    // on the same edge that loads the new mode; switch_pending follows the
    // current state and therefore trails the FSM by one clock.
    always_ff @(posedge clk) begin
        if (rst) begin
            blank_out_r      <= BLANK_EN;
            switch_pending_r <= 1'b0;
        end else begin
            blank_out_r      <= (state_nxt_s == ST_BLANK);
            switch_pending_r <= (state_r == ST_PENDING);
        end
    end

    assign mode_sel       = mode_sel_r;
    assign blank_out      = blank_out_r;
    assign switch_pending = switch_pending_r;

`ifdef FRAME_MODE_CTRL_STATS_EN
    localparam logic [LINE_CNT_W-1:0] LINE_CNT_MAX = {LINE_CNT_W{1'b1}};

    logic [FRAME_CNT_W-1:0] frame_cnt_r;
    logic [LINE_CNT_W-1:0]  line_cnt_r;
    logic [LINE_CNT_W-1:0]  lines_per_frame_r;
    logic                   de_d_r;
    logic                   de_rise_s;
    logic                   stats_unused_s;

    assign de_rise_s      = de_in & ~de_d_r;
    assign stats_unused_s = hs_in;

    // Frame counter, wraps naturally at its width.
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_cnt_r <= {FRAME_CNT_W{1'b0}};
        end else if (frame_start_s) begin
            frame_cnt_r <= frame_cnt_r + FRAME_CNT_W'(1);
        end else begin
            frame_cnt_r <= frame_cnt_r;
        end
    end

    // Line counter on de rising edges; snapshot and clear at frame start.
    always_ff @(posedge clk) begin
        if (rst) begin
            de_d_r            <= 1'b0;
            line_cnt_r        <= {LINE_CNT_W{1'b0}};
            lines_per_frame_r <= {LINE_CNT_W{1'b0}};
        end else begin
            de_d_r <= de_in;
            if (frame_start_s) begin
                lines_per_frame_r <= line_cnt_r;
                line_cnt_r        <= {LINE_CNT_W{1'b0}};
            end else if (de_rise_s && (line_cnt_r != LINE_CNT_MAX)) begin
                line_cnt_r <= line_cnt_r + LINE_CNT_W'(1);
            end else begin
                line_cnt_r <= line_cnt_r;
            end
        end
    end

    assign frame_cnt       = frame_cnt_r;
    assign lines_per_frame = lines_per_frame_r;
`else
    logic stats_unused_s;

    assign stats_unused_s  = hs_in ^ de_in;
    assign frame_cnt       = {FRAME_CNT_W{1'b0}};
    assign lines_per_frame = {LINE_CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_frame_mode_ctrl.sv
// -----------------------------------------------------------------------------
// tb_frame_mode_ctrl
// Directed bench for frame_mode_ctrl with DEB_CYCLES = 4, BLANK_FRAMES = 2,
// 100-cycle frames (vs high for 5 cycles, 40 one-cycle de pulses per frame).
// Tasks push timed expectations into a scoreboard queue; a negedge monitor
// pops and compares them when their cycle arrives. Tasks also make inline
// checks of steady-state properties.
// -----------------------------------------------------------------------------
module tb_frame_mode_ctrl;

    localparam int FRAME_LEN = 100;

`ifdef FRAME_MODE_CTRL_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    localparam int K_MODE  = 0;
    localparam int K_BLANK = 1;
    localparam int K_PEND  = 2;
    localparam int K_FCNT  = 3;
    localparam int K_LINES = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        vs_in;
    logic        hs_in;
    logic        de_in;
    logic [3:0]  sw_opt;
    logic [3:0]  mode_sel;
    logic        blank_out;
    logic        switch_pending;
    logic [15:0] frame_cnt;
    logic [11:0] lines_per_frame;

    typedef struct {
        int cyc;
        int kind;
        int exp;
    } sb_entry_t;

    sb_entry_t sb_q[$];

    int cyc    = 0;
    int fpos   = 10;
    int errors = 0;
    int checks = 0;
    int g_f    = 0;
    bit saw_blank;
    bit saw_pend;
    bit saw_mode_nz;

    frame_mode_ctrl #(
        .DEB_CYCLES   (4),
        .BLANK_FRAMES (2)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .vs_in           (vs_in),
        .hs_in           (hs_in),
        .de_in           (de_in),
        .sw_opt          (sw_opt),
        .mode_sel        (mode_sel),
        .blank_out       (blank_out),
        .switch_pending  (switch_pending),
        .frame_cnt       (frame_cnt),
        .lines_per_frame (lines_per_frame)
    );

    initial begin
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    function automatic string kname(input int k);
        case (k)
            K_MODE:  return "mode_sel";
            K_BLANK: return "blank_out";
            K_PEND:  return "switch_pending";
            K_FCNT:  return "frame_cnt";
            K_LINES: return "lines_per_frame";
            default: return "unknown";
        endcase
    endfunction

    // Cycle number (value of cyc after the edge) of the k-th upcoming frame start.
    function automatic int fs_cyc(input int k);
        return cyc + 1 + ((FRAME_LEN - fpos) % FRAME_LEN) + FRAME_LEN * (k - 1);
    endfunction

    // Sorted insert so tasks may push expectations in any order.
    task automatic expect_at(input int c, input int k, input int v);
        sb_entry_t e;
        int        i;
        e.cyc  = c;
        e.kind = k;
        e.exp  = v;
        i      = 0;
        while (i < sb_q.size() && sb_q[i].cyc <= c) i++;
        sb_q.insert(i, e);
    endtask

    // Scoreboard monitor: compare every entry that is due after the last edge.
    always @(negedge clk) begin : sb_monitor
        sb_entry_t   e;
        logic [15:0] obs;
        while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
            e = sb_q.pop_front();
            case (e.kind)
                K_MODE:  obs = {12'd0, mode_sel};
                K_BLANK: obs = {15'd0, blank_out};
                K_PEND:  obs = {15'd0, switch_pending};
                K_FCNT:  obs = frame_cnt;
                K_LINES: obs = {4'd0, lines_per_frame};
                default: obs = 16'hFFFF;
            endcase
            checks++;
            if (e.cyc != cyc) begin
                errors++;
                $display("FAIL sb_%s@%0d: compared late at cycle %0d, expected %0d",
                         kname(e.kind), e.cyc, cyc, e.exp);
            end else if (obs !== 16'(e.exp)) begin
                errors++;
                $display("FAIL sb_%s@%0d: got %0d, expected %0d",
                         kname(e.kind), e.cyc, obs, e.exp);
            end
        end
    end

    // One clock of the video timing generator plus sticky observation flags.
    task automatic step();
        vs_in = (fpos < 5) ? 1'b1 : 1'b0;
        de_in = (fpos >= 10 && fpos < 90 && (fpos % 2) == 0) ? 1'b1 : 1'b0;
        hs_in = ((fpos % 2) == 1) ? 1'b1 : 1'b0;
        @(posedge clk);
        #1;
        fpos = (fpos + 1) % FRAME_LEN;
        if (blank_out !== 1'b0)      saw_blank   = 1'b1;
        if (switch_pending !== 1'b0) saw_pend    = 1'b1;
        if (mode_sel !== 4'd0)       saw_mode_nz = 1'b1;
    endtask

    task automatic advance_to(input int p);
        while (fpos != p) step();
    endtask

    task automatic run_until(input int c);
        while (cyc < c) step();
    endtask

    task automatic clear_flags();
        saw_blank   = 1'b0;
        saw_pend    = 1'b0;
        saw_mode_nz = 1'b0;
    endtask

    task automatic test_reset();
        rst    = 1'b1;
        sw_opt = 4'd0;
        fpos   = 10;
        repeat (3) step();
        checks++;
        if (mode_sel !== 4'd0) begin
            errors++; $display("FAIL reset_mode_sel: got %0d, expected 0", mode_sel);
        end
        checks++;
        if (blank_out !== 1'b1) begin
            errors++; $display("FAIL reset_blank_out: got %0b, expected 1", blank_out);
        end
        checks++;
        if (switch_pending !== 1'b0) begin
            errors++; $display("FAIL reset_switch_pending: got %0b, expected 0", switch_pending);
        end
        checks++;
        if (frame_cnt !== 16'd0) begin
            errors++; $display("FAIL reset_frame_cnt: got %0d, expected 0", frame_cnt);
        end
        checks++;
        if (lines_per_frame !== 12'd0) begin
            errors++; $display("FAIL reset_lines_per_frame: got %0d, expected 0", lines_per_frame);
        end
        rst = 1'b0;
    endtask

    // Power-up blanking across three frames, plus statistics.
    task automatic test_power_up_blank();
        int f1, f2, f3;
        clear_flags();
        f1 = fs_cyc(1);
        f2 = fs_cyc(2);
        f3 = fs_cyc(3);
        expect_at(f1,     K_BLANK, 1);
        expect_at(f2 - 1, K_BLANK, 1);
        expect_at(f2,     K_BLANK, 0);
        expect_at(f2,     K_PEND,  0);
        expect_at(f3,     K_BLANK, 0);
        expect_at(f1,     K_FCNT,  STATS ? 1 : 0);
        expect_at(f3,     K_FCNT,  STATS ? 3 : 0);
        expect_at(f3,     K_LINES, STATS ? 40 : 0);
        run_until(f3 + 1);
        checks++;
        if (saw_mode_nz) begin
            errors++; $display("FAIL powerup_mode_sel: got nonzero, expected 0 throughout");
        end
    endtask

    // A 3-cycle pulse is shorter than the debounce window and must vanish.
    task automatic test_glitch();
        int s;
        advance_to(30);
        clear_flags();
        s = cyc + 1;
        expect_at(s + 8, K_PEND, 0);
        expect_at(s + 8, K_MODE, 0);
        sw_opt = 4'd1;
        repeat (3) step();
        sw_opt = 4'd0;
        repeat (20) step();
        checks++;
        if (saw_pend) begin
            errors++; $display("FAIL glitch_pending: got 1, expected 0 throughout");
        end
        checks++;
        if (saw_mode_nz) begin
            errors++; $display("FAIL glitch_mode_sel: got nonzero, expected 0 throughout");
        end
    endtask

    // Request raised then withdrawn; at_edge lands the withdrawal on the
    // same cycle as the frame start, where the withdrawal must win.
    task automatic test_withdraw(input bit at_edge);
        int s, f;
        advance_to(at_edge ? 83 : 10);
        clear_flags();
        s = cyc + 1;
        f = fs_cyc(1);
        expect_at(s + 7,  K_PEND, 0);
        expect_at(s + 8,  K_PEND, 1);
        expect_at(s + 17, K_PEND, 1);
        expect_at(s + 18, K_PEND, 0);
        expect_at(f,      K_MODE, 0);
        expect_at(f,      K_BLANK, 0);
        expect_at(f + 1,  K_MODE, 0);
        sw_opt = 4'd1;
        repeat (10) step();
        sw_opt = 4'd0;
        run_until(f + 5);
        checks++;
        if (saw_blank) begin
            errors++; $display("FAIL withdraw%0d_blank: got 1, expected 0 throughout", at_edge);
        end
        checks++;
        if (saw_mode_nz) begin
            errors++; $display("FAIL withdraw%0d_mode_sel: got nonzero, expected 0 throughout", at_edge);
        end
    endtask

    // 0 -> 1 request applied at the next frame start, then two blanked frames.
    task automatic test_mode_switch();
        int s, f;
        advance_to(20);
        s = cyc + 1;
        f = fs_cyc(1);
        g_f = f;
        expect_at(s + 7,   K_PEND,  0);
        expect_at(s + 8,   K_PEND,  1);
        expect_at(f - 1,   K_MODE,  0);
        expect_at(f - 1,   K_BLANK, 0);
        expect_at(f,       K_MODE,  1);
        expect_at(f,       K_BLANK, 1);
        expect_at(f,       K_PEND,  1);
        expect_at(f + 1,   K_PEND,  0);
        expect_at(f + 199, K_BLANK, 1);
        expect_at(f + 200, K_BLANK, 0);
        expect_at(f + 200, K_MODE,  1);
        sw_opt = 4'd1;
        run_until(f + 10);
    endtask

    // 1 -> 0 during BLANK: held off until BLANK ends, applied one frame later.
    task automatic test_blank_change();
        int f;
        f = g_f;
        checks++;
        if (blank_out !== 1'b1) begin
            errors++; $display("FAIL blank_change_entry: got %0b, expected 1", blank_out);
        end
        expect_at(f + 150, K_MODE,  1);
        expect_at(f + 150, K_PEND,  0);
        expect_at(f + 201, K_PEND,  0);
        expect_at(f + 202, K_PEND,  1);
        expect_at(f + 299, K_MODE,  1);
        expect_at(f + 300, K_MODE,  0);
        expect_at(f + 300, K_BLANK, 1);
        expect_at(f + 300, K_PEND,  1);
        expect_at(f + 301, K_PEND,  0);
        expect_at(f + 499, K_BLANK, 1);
        expect_at(f + 500, K_BLANK, 0);
        sw_opt = 4'd0;
        run_until(f + 505);
    endtask

    // Reset in the middle of BLANK must clear the mode and restart blanking.
    task automatic test_reset_mid();
        int f, f1, f2;
        advance_to(20);
        f = fs_cyc(1);
        sw_opt = 4'd1;
        run_until(f + 110);
        checks++;
        if (mode_sel !== 4'd1) begin
            errors++; $display("FAIL reset_mid_pre_mode: got %0d, expected 1", mode_sel);
        end
        rst    = 1'b1;
        sw_opt = 4'd0;
        repeat (2) step();
        rst = 1'b0;
        checks++;
        if (mode_sel !== 4'd0) begin
            errors++; $display("FAIL reset_mid_mode_sel: got %0d, expected 0", mode_sel);
        end
        checks++;
        if (switch_pending !== 1'b0) begin
            errors++; $display("FAIL reset_mid_pending: got %0b, expected 0", switch_pending);
        end
        checks++;
        if (frame_cnt !== 16'd0) begin
            errors++; $display("FAIL reset_mid_frame_cnt: got %0d, expected 0", frame_cnt);
        end
        f1 = fs_cyc(1);
        f2 = fs_cyc(2);
        expect_at(f1,     K_BLANK, 1);
        expect_at(f2 - 1, K_BLANK, 1);
        expect_at(f2,     K_BLANK, 0);
        expect_at(f2,     K_MODE,  0);
        run_until(f2 + 2);
    endtask

    initial begin
        rst    = 1'b1;
        sw_opt = 4'd0;
        vs_in  = 1'b0;
        hs_in  = 1'b0;
        de_in  = 1'b0;
        clear_flags();
        test_reset();
        test_power_up_blank();
        test_glitch();
        test_withdraw(1'b0);
        test_withdraw(1'b1);
        test_mode_switch();
        test_blank_change();
        test_reset_mid();
        for (int i = 0; i < 50 && sb_q.size() > 0; i++) step();
        checks++;
        if (sb_q.size() != 0) begin
            errors++; $display("FAIL sb_drain: got %0d pending entries, expected 0", sb_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
